memory_row_reader: RTL and testbench

Read-side controller downstream of `BlockMemoryStorage`. On a start pulse it puts the storage into read mode and scans every (word, letter) cell in ascending order. It collects the 1-bit `storedValue` responses, packs each word's letters into one row bitmap, and buffers finished rows in a small FIFO for a valid/ready consumer. It drives the storage's inquiry port and is the block that turns stored contents into a row-wise output stream.

---
 rtl/memory_row_reader_pkg.sv | 25 ++
 rtl/memory_row_reader_if.sv | 47 ++++
 rtl/memory_row_reader_row_fifo.sv | 58 +++++
 rtl/memory_row_reader.sv | 184 ++++++++++++++++++
 tb/tb_memory_row_reader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_row_reader_pkg.sv
// Shared widths, FSM encoding and sizing helpers for the row reader and its FIFO.
package memory_row_reader_pkg;

    localparam int unsigned DEFAULT_ROW_INDEX_BITS = 5;
    localparam int unsigned DEFAULT_COL_INDEX_BITS = 3;
    localparam int unsigned DEFAULT_READ_LATENCY   = 2;
    localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } readerState_e;

    // One bit per letter in a row.
    function automatic int unsigned rowWidth(input int unsigned colIndexBits);
        return 32'd1 << colIndexBits;
    endfunction

    // Count must represent 0..depth inclusive.
    function automatic int unsigned fifoCountBits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/memory_row_reader_if.sv
// Storage inquiry port plus the row stream towards the consumer.
interface memory_row_reader_if #(
    parameter int unsigned ROWINDEXBITS = 5,
    parameter int unsigned COLINDEXBITS = 3
);
    import memory_row_reader_pkg::*;

    localparam int unsigned W = rowWidth(COLINDEXBITS);

    logic                    readMemory;
    logic                    inquiry;
    logic                    readReady;
    logic [ROWINDEXBITS-1:0] inquiryWordIndex;
    logic [COLINDEXBITS-1:0] inquiryLetterIndex;
    logic                    storedValue;
    logic                    rowValid;
    logic                    rowReady;
    logic [W-1:0]            rowData;
    logic [ROWINDEXBITS-1:0] rowIndex;

    modport master (
        output readMemory,
        output inquiry,
        output inquiryWordIndex,
        output inquiryLetterIndex,
        input  readReady,
        input  storedValue,
        output rowValid,
        input  rowReady,
        output rowData,
        output rowIndex
    );

    modport slave (
        input  readMemory,
        input  inquiry,
        input  inquiryWordIndex,
        input  inquiryLetterIndex,
        output readReady,
        output storedValue,
        input  rowValid,
        output rowReady,
        input  rowData,
        input  rowIndex
    );

endinterface

// File: rtl/memory_row_reader_row_fifo.sv
// Synchronous FIFO with occupancy count and a valid/ready pop side.
module row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pushValid,
    input  logic [WIDTH-1:0]        pushData,
    input  logic                    popReady,
    output logic                    popValid,
    output logic [WIDTH-1:0]        popData,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned PTRBITS   = $clog2(DEPTH);
    localparam int unsigned COUNTBITS = PTRBITS + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTRBITS-1:0] wrPtr;
    logic [PTRBITS-1:0] rdPtr;
    logic               doPush;
    logic               doPop;

    // Head is zeroed while empty so stale storage never leaks out.
    always_comb begin
        popValid = (count != '0);
        doPop    = popValid && popReady;
        doPush   = pushValid && ((count != COUNTBITS'(DEPTH)) || doPop);
        popData  = popValid ? mem[rdPtr] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTRBITS'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTRBITS'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + COUNTBITS'(1);
                2'b01:   count <= count - COUNTBITS'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/memory_row_reader.sv
// Scans every (word, letter) cell of the storage and streams each word out as a row bitmap.
module memory_row_reader
    import memory_row_reader_pkg::*;
#(
    parameter int unsigned ROWINDEXBITS = DEFAULT_ROW_INDEX_BITS,
    parameter int unsigned COLINDEXBITS = DEFAULT_COL_INDEX_BITS,
    parameter int unsigned READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    memory_row_reader_if.master bus
);
    localparam int unsigned W         = rowWidth(COLINDEXBITS);
    localparam int unsigned COUNTBITS = fifoCountBits(FIFO_DEPTH);
    localparam logic [ROWINDEXBITS-1:0] ROW_MAX    = '1;
    localparam logic [COLINDEXBITS-1:0] LETTER_MAX = '1;

    typedef struct packed {
        logic                    valid;
        logic [ROWINDEXBITS-1:0] row;
        logic [COLINDEXBITS-1:0] letter;
    } flight_t;

    typedef struct packed {
        logic [ROWINDEXBITS-1:0] row;
        logic [W-1:0]            bits;
    } rowEntry_t;

    readerState_e            state;
    readerState_e            stateNext;
    logic [ROWINDEXBITS-1:0] wordIdx;
    logic [ROWINDEXBITS-1:0] wordNext;
    logic [COLINDEXBITS-1:0] letterIdx;
    logic [COLINDEXBITS-1:0] letterNext;
    logic [COUNTBITS-1:0]    rowsInFlight;
    logic [COUNTBITS-1:0]    rowsInFlightNext;
    logic [COUNTBITS-1:0]    fifoCount;
    logic [COUNTBITS:0]      creditSum;
    logic                    busyReg;
    logic                    busyNext;
    logic                    doneReg;
    logic                    doneNext;
    logic                    inquiry;
    logic                    accept;
    logic                    push;
    logic                    lastArrival;
    logic                    fifoValid;
    flight_t                 pipe [READ_LATENCY];
    flight_t                 arrival;
    logic [W-1:0]            assembly;
    logic [W-1:0]            assembled;
    rowEntry_t               pushEntry;
    rowEntry_t               headEntry;

    // Next-state, inquiry credit and row assembly.
    always_comb begin
        stateNext        = state;
        wordNext         = wordIdx;
        letterNext       = letterIdx;
        rowsInFlightNext = rowsInFlight;
        doneNext         = 1'b0;

        // Buffered plus outstanding rows must leave room before a new row may begin.
        creditSum = {1'b0, fifoCount} + {1'b0, rowsInFlight};
        inquiry   = (state == SCAN) &&
                    ((letterIdx != '0) || (creditSum < (COUNTBITS + 1)'(FIFO_DEPTH)));
        accept    = inquiry && bus.readReady;

        arrival     = pipe[READ_LATENCY-1];
        push        = arrival.valid && (arrival.letter == LETTER_MAX);
        lastArrival = push && (arrival.row == ROW_MAX);
        assembled   = assembly;
        if (arrival.valid) begin
            assembled[arrival.letter] = bus.storedValue;
        end
        pushEntry = '{row: arrival.row, bits: assembled};

        if (accept && (letterIdx == '0)) begin
            rowsInFlightNext = rowsInFlightNext + COUNTBITS'(1);
        end
        if (push) begin
            rowsInFlightNext = rowsInFlightNext - COUNTBITS'(1);
        end

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext  = SCAN;
                    wordNext   = '0;
                    letterNext = '0;
                end
            end
            SCAN: begin
                if (accept) begin
                    letterNext = letterIdx + COLINDEXBITS'(1);
                    if (letterIdx == LETTER_MAX) begin
                        wordNext = wordIdx + ROWINDEXBITS'(1);
                        if (wordIdx == ROW_MAX) begin
                            stateNext = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (lastArrival) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wordIdx      <= '0;
            letterIdx    <= '0;
            rowsInFlight <= '0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
        end else begin
            state        <= stateNext;
            wordIdx      <= wordNext;
            letterIdx    <= letterNext;
            rowsInFlight <= rowsInFlightNext;
            busyReg      <= busyNext;
            doneReg      <= doneNext;
        end
    end

    // Tags each accepted inquiry so its response lands in the right bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: accept, row: wordIdx, letter: letterIdx};
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || push) begin
            assembly <= '0;
        end else if (arrival.valid) begin
            assembly <= assembled;
        end
    end

    row_fifo #(
        .WIDTH (ROWINDEXBITS + W),
        .DEPTH (FIFO_DEPTH)
    ) rowFifo (
        .clock     (clock),
        .reset     (reset),
        .pushValid (push),
        .pushData  (pushEntry),
        .popReady  (bus.rowReady),
        .popValid  (fifoValid),
        .popData   (headEntry),
        .count     (fifoCount)
    );

    assign bus.inquiry            = inquiry;
    assign bus.inquiryWordIndex   = wordIdx;
    assign bus.inquiryLetterIndex = letterIdx;
    assign bus.readMemory         = busyReg;
    assign bus.rowValid           = fifoValid;
    assign bus.rowData            = headEntry.bits;
    assign bus.rowIndex           = headEntry.row;
    assign busy                   = busyReg;
    assign done                   = doneReg;

endmodule

// File: tb/tb_memory_row_reader.sv
// Random-content scans of memory_row_reader checked against a cell/row reference model.
module tb_memory_row_reader;
    localparam int ROWS    = 32;
    localparam int LETTERS = 8;
    localparam int CELLS   = ROWS * LETTERS;

    logic clock;
    logic reset;
    logic start;
    logic busy;
    logic done;

    memory_row_reader_if #(.ROWINDEXBITS(5), .COLINDEXBITS(3)) bus();

    memory_row_reader #(
        .ROWINDEXBITS (5),
        .COLINDEXBITS (3),
        .READ_LATENCY (2),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         nCompared;
    int         nMismatched;
    logic [7:0] stor [ROWS];
    logic [7:0] gotRows [ROWS];
    logic [1:0] hist;
    int         cyc;
    int         expCell;
    int         accepts;
    int         nextPop;
    int         doneCount;
    int         doneCycle;
    int         strayA;
    int         strayB;
    int         rdMode;
    int         rowMode;
    bit         rrToggle;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        expCell   = 0;
        accepts   = 0;
        nextPop   = 0;
        doneCount = 0;
        doneCycle = -1;
    endtask

    task automatic fillParity();
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < LETTERS; l++) begin
                stor[r][l] = 1'((r + l) & 1);
            end
        end
    endtask

    task automatic fillRandom();
        for (int r = 0; r < ROWS; r++) begin
            stor[r] = 8'($urandom);
        end
    endtask

    // One cycle: drive inputs at the falling edge, play the storage, and score the outputs.
    task automatic step(input bit s, input bit r);
        logic v;
        @(negedge clock);
        cyc++;
        reset = r;
        start = s || (cyc == strayA) || (cyc == strayB);
        case (rdMode)
            0: bus.readReady = 1'b1;
            1: begin
                rrToggle      = ~rrToggle;
                bus.readReady = rrToggle;
            end
            default: bus.readReady = ($urandom_range(0, 3) != 0);
        endcase
        case (rowMode)
            0:       bus.rowReady = 1'b1;
            1:       bus.rowReady = 1'b0;
            default: bus.rowReady = 1'($urandom_range(0, 1));
        endcase
        bus.storedValue = hist[1];
        v = 1'b0;
        if (!r) begin
            if (bus.inquiry && bus.readReady) begin
                checkValue("inq_cell", 64'({bus.inquiryWordIndex, bus.inquiryLetterIndex}), 64'(expCell));
                v = stor[bus.inquiryWordIndex][bus.inquiryLetterIndex];
                expCell++;
                accepts++;
            end
            if (bus.rowValid && bus.rowReady) begin
                if (nextPop < ROWS) begin
                    checkValue("row_index", 64'(bus.rowIndex), 64'(nextPop));
                    checkValue("row_data", 64'(bus.rowData), 64'(stor[nextPop]));
                    gotRows[nextPop] = bus.rowData;
                end else begin
                    checkValue("rows_popped", 64'(nextPop + 1), 64'(ROWS));
                end
                nextPop++;
            end
            if (done) begin
                doneCount++;
                doneCycle = cyc;
                checkValue("busy_at_done", 64'(busy), 64'(0));
                checkValue("valid_at_done", 64'(bus.rowValid), 64'(1));
            end
        end
        hist = {hist[0], v};
        if (s) cyc = 0;
    endtask

    task automatic finishScan(input int limit);
        int n;
        n = 0;
        while ((doneCount == 0 || nextPop < ROWS) && n < limit) begin
            step(1'b0, 1'b0);
            n++;
        end
        checkValue("rows_out", 64'(nextPop), 64'(ROWS));
        checkValue("done_count", 64'(doneCount), 64'(1));
        checkValue("accepts", 64'(accepts), 64'(CELLS));
    endtask

    task automatic runScan(input int limit);
        resetModel();
        step(1'b1, 1'b0);
        finishScan(limit);
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_busy"}, 64'(busy), 64'(0));
        checkValue({tag, "_done"}, 64'(done), 64'(0));
        checkValue({tag, "_readmem"}, 64'(bus.readMemory), 64'(0));
        checkValue({tag, "_inquiry"}, 64'(bus.inquiry), 64'(0));
        checkValue({tag, "_word"}, 64'(bus.inquiryWordIndex), 64'(0));
        checkValue({tag, "_letter"}, 64'(bus.inquiryLetterIndex), 64'(0));
        checkValue({tag, "_rowvalid"}, 64'(bus.rowValid), 64'(0));
        checkValue({tag, "_rowdata"}, 64'(bus.rowData), 64'(0));
        checkValue({tag, "_rowindex"}, 64'(bus.rowIndex), 64'(0));
    endtask

    initial begin
        nCompared       = 0;
        nMismatched     = 0;
        reset           = 1'b1;
        start           = 1'b1;
        bus.readReady   = 1'b1;
        bus.rowReady    = 1'b1;
        bus.storedValue = 1'b0;
        hist            = '0;
        rdMode          = 0;
        rowMode         = 0;
        rrToggle        = 1'b0;
        cyc             = 0;
        strayA          = -1;
        strayB          = -1;
        resetModel();

        // Reset held with start high.
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        checkAllZero("reset");
        step(1'b0, 1'b0);
        checkValue("reset_idle_busy", 64'(busy), 64'(0));

        // Unstalled scan of the parity pattern.
        fillParity();
        runScan(2000);
        checkValue("done_cycle", 64'(doneCycle), 64'(259));
        checkValue("row0_data", 64'(gotRows[0]), 64'(8'hAA));
        checkValue("row1_data", 64'(gotRows[1]), 64'(8'h55));

        // Consumer backpressure: only FIFO_DEPTH rows may be started.
        fillRandom();
        resetModel();
        rowMode = 1;
        step(1'b1, 1'b0);
        repeat (300) step(1'b0, 1'b0);
        checkValue("bp_accepts", 64'(accepts), 64'(32));
        checkValue("bp_inquiry", 64'(bus.inquiry), 64'(0));
        checkValue("bp_head_valid", 64'(bus.rowValid), 64'(1));
        checkValue("bp_head_index", 64'(bus.rowIndex), 64'(0));
        checkValue("bp_head_data", 64'(bus.rowData), 64'(stor[0]));
        checkValue("bp_busy", 64'(busy), 64'(1));
        rowMode = 0;
        finishScan(2000);

        // Storage ready toggling every cycle.
        fillRandom();
        rdMode = 1;
        runScan(3000);
        rdMode = 0;

        // Reset in the middle of a randomly stalled scan, then a fresh scan.
        fillRandom();
        rdMode  = 2;
        rowMode = 2;
        resetModel();
        step(1'b1, 1'b0);
        while (cyc < 99) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checkAllZero("midreset");
        runScan(5000);

        // Stray starts during SCAN (cycle 50) and DRAIN (cycle 258).
        rdMode  = 0;
        rowMode = 0;
        fillRandom();
        strayA = 50;
        strayB = 258;
        runScan(2000);
        strayA = -1;
        strayB = -1;
        repeat (10) step(1'b0, 1'b0);
        checkValue("stray_done_count", 64'(doneCount), 64'(1));
        checkValue("stray_done_cycle", 64'(doneCycle), 64'(259));
        checkValue("stray_busy", 64'(busy), 64'(0));

        // Start coinciding with reset.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        checkValue("start_reset_busy", 64'(busy), 64'(0));
        checkValue("start_reset_inquiry", 64'(bus.inquiry), 64'(0));
        step(1'b0, 1'b0);
        checkValue("start_reset_readmem", 64'(bus.readMemory), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
